// File: rtl/stoch_mul_core.sv
// Stochastic-computing multiplier: two LFSR-driven SNGs feed an AND/XNOR product
// stream whose ones are counted over a 2^WIN_LOG2-cycle window.
module stoch_mul_core #(
  parameter int          WIDTH    = 4,
  parameter int          WIN_LOG2 = 7,
  parameter logic [30:0] SEED_A   = 31'd1,
  parameter logic [30:0] SEED_B   = 31'h2AAA_5555
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    a_in,
  input  logic [WIDTH-1:0]    b_in,
  input  logic                mode,
  input  logic                cont,
  input  logic                start,
  output logic                busy,
  output logic                result_valid,
  output logic [WIN_LOG2:0]   result_count,
  output logic [WIDTH-1:0]    result_scaled
);

  localparam int                SHIFT = WIN_LOG2 - WIDTH;
  localparam logic [WIN_LOG2:0] SAT   = (WIN_LOG2+1)'((1 << WIDTH) - 1);

  typedef enum logic [1:0] {IDLE, WARM, ACC} state_t;

  state_t              state, state_nxt;
  logic [30:0]         lfsr_a, lfsr_b;
  logic [WIDTH-1:0]    a_q, b_q;
  logic                mode_q;
  logic                sn_a, sn_b, prod;
  logic                warm_cnt;
  logic [WIN_LOG2-1:0] win_cnt;
  logic [WIN_LOG2:0]   acc;
  logic [WIN_LOG2:0]   sum;
  logic [WIN_LOG2:0]   shifted;
  logic [WIDTH-1:0]    scaled_c;
  logic                load;
  logic                last;

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = WARM;
        end
      end
      WARM: begin
        if (warm_cnt) state_nxt = ACC;
      end
      ACC: begin
        if (win_cnt == '1) begin
          last = 1'b1;
          // Continuous mode relatches operands on the same edge that closes the window
          if (cont) begin
            load      = 1'b1;
            state_nxt = WARM;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sum      = acc + {{WIN_LOG2{1'b0}}, prod};
    shifted  = sum >> SHIFT;
    scaled_c = (shifted > SAT) ? WIDTH'(SAT) : WIDTH'(shifted);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state         <= IDLE;
      lfsr_a        <= SEED_A;
      lfsr_b        <= SEED_B;
      a_q           <= '0;
      b_q           <= '0;
      mode_q        <= 1'b0;
      sn_a          <= 1'b0;
      sn_b          <= 1'b0;
      prod          <= 1'b0;
      warm_cnt      <= 1'b0;
      win_cnt       <= '0;
      acc           <= '0;
      result_valid  <= 1'b0;
      result_count  <= '0;
      result_scaled <= '0;
    end else begin
      state        <= state_nxt;
      lfsr_a       <= {lfsr_a[29:0], lfsr_a[27] ^ lfsr_a[30]};
      lfsr_b       <= {lfsr_b[29:0], lfsr_b[27] ^ lfsr_b[30]};
      sn_a         <= (lfsr_a[WIDTH-1:0] < a_q);
      sn_b         <= (lfsr_b[WIDTH-1:0] < b_q);
      prod         <= mode_q ? ~(sn_a ^ sn_b) : (sn_a & sn_b);
      warm_cnt     <= (state == WARM) ? ~warm_cnt : 1'b0;
      win_cnt      <= (state == ACC) ? win_cnt + WIN_LOG2'(1) : '0;
      result_valid <= 1'b0;
      if (load) begin
        a_q    <= a_in;
        b_q    <= b_in;
        mode_q <= mode;
        acc    <= '0;
      end else if (state == ACC) begin
        acc <= sum;
      end
      if (last) begin
        result_count  <= sum;
        result_scaled <= scaled_c;
        result_valid  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stoch_mul_core.sv
// Scoreboard bench for stoch_mul_core: expected windows are computed from an
// edge-indexed LFSR sequence model and popped by a monitor on result_valid.
module tb_stoch_mul_core;

  localparam int          W   = 4;
  localparam int          WL  = 7;
  localparam int          WIN = 1 << WL;
  localparam int          LAT = 2 + WIN;
  localparam logic [30:0] SA  = 31'd1;
  localparam logic [30:0] SB  = 31'h2AAA_5555;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  a_in = '0, b_in = '0;
  logic          mode = 1'b0, cont = 1'b0, start = 1'b0;
  logic          busy, result_valid;
  logic [WL:0]   result_count;
  logic [W-1:0]  result_scaled;

  stoch_mul_core #(.WIDTH(W), .WIN_LOG2(WL), .SEED_A(SA), .SEED_B(SB)) dut (
    .clk(clk), .rst_n(rst), .a_in(a_in), .b_in(b_in), .mode(mode), .cont(cont),
    .start(start), .busy(busy), .result_valid(result_valid),
    .result_count(result_count), .result_scaled(result_scaled)
  );

  always #5 clk = ~clk;

  typedef struct {int count; int scaled; int edge_idx;} exp_t;
  exp_t q[$];

  int n_cmp = 0, n_bad = 0;
  int edge_cnt = 0, valid_seen = 0, busy_cycles = 0;

  // Edges since reset release; LFSR value after k such edges is the seed stepped k times.
  always @(posedge clk or posedge rst) begin
    if (rst) edge_cnt = 0;
    else     edge_cnt = edge_cnt + 1;
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [30:0] step(input logic [30:0] l);
    return {l[29:0], l[27] ^ l[30]};
  endfunction

  // Window starting with start sampled at edge n0 uses LFSR states n0 .. n0+WIN-1.
  function automatic int model_count(input int n0, input int a, input int b, input int m);
    logic [30:0] la, lb;
    bit sa, sb;
    int c;
    la = SA; lb = SB; c = 0;
    for (int i = 0; i < n0; i++) begin
      la = step(la);
      lb = step(lb);
    end
    for (int i = 0; i < WIN; i++) begin
      sa = (int'(la[W-1:0]) < a);
      sb = (int'(lb[W-1:0]) < b);
      if (m != 0 ? (sa == sb) : (sa && sb)) c++;
      la = step(la);
      lb = step(lb);
    end
    return c;
  endfunction

  function automatic int scale(input int c);
    int s;
    s = c >> (WL - W);
    return (s > (1 << W) - 1) ? (1 << W) - 1 : s;
  endfunction

  task automatic push_exp(input int n0, input int a, input int b, input int m);
    exp_t e;
    e.count    = model_count(n0, a, b, m);
    e.scaled   = scale(e.count);
    e.edge_idx = n0 + LAT;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (busy) busy_cycles++;
    if (result_valid) begin
      exp_t e;
      valid_seen++;
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got count %0d, expected no result (t=%0t)",
                 result_count, $time);
      end else begin
        e = q.pop_front();
        check("result_count", int'(result_count), e.count);
        check("result_scaled", int'(result_scaled), e.scaled);
        check("valid_edge", edge_cnt, e.edge_idx);
      end
    end
  end

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (!busy && q.size() == 0) break;
    end
    check("done_in_budget", q.size() + int'(busy), 0);
    q.delete();
  endtask

  task automatic run_one(input int a, input int b, input int m);
    int bc, vs, n0;
    @(posedge clk);
    #1;
    a_in = W'(a); b_in = W'(b); mode = m[0]; cont = 1'b0; start = 1'b1;
    n0 = edge_cnt + 1;
    push_exp(n0, a, b, m);
    bc = busy_cycles; vs = valid_seen;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(LAT + 20);
    check("busy_cycles", busy_cycles - bc, LAT);
    check("valid_pulses", valid_seen - vs, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int vs, bc, n0;
    int vals[3] = '{3, 8, 15};

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(result_valid), 0);
    check("rst_count", int'(result_count), 0);
    check("rst_scaled", int'(result_scaled), 0);
    rst = 1'b0;

    vs = valid_seen;
    repeat (200) @(posedge clk);
    #1;
    check("idle_no_valid", valid_seen - vs, 0);
    check("idle_busy", int'(busy), 0);

    run_one(0, 15, 0);
    check("uni_zero_count", int'(result_count), 0);
    run_one(0, 0, 1);
    check("bip_full_count", int'(result_count), WIN);
    check("bip_full_scaled", int'(result_scaled), (1 << W) - 1);

    for (int m = 0; m < 2; m++)
      foreach (vals[i])
        foreach (vals[j])
          run_one(vals[i], vals[j], m);

    for (int k = 0; k < 8; k++)
      run_one(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));

    // Continuous: window 1 bipolar (full count), mode switched mid-window feeds window 2.
    @(posedge clk);
    #1;
    a_in = '0; b_in = '0; mode = 1'b1; cont = 1'b1; start = 1'b1;
    n0 = edge_cnt + 1;
    push_exp(n0, 0, 0, 1);
    push_exp(n0 + LAT, 0, 0, 0);
    bc = busy_cycles; vs = valid_seen;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (40) @(posedge clk);
    #1 mode = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (LAT) @(posedge clk);
    #1 cont = 1'b0; b_in = 4'd15; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; b_in = '0;
    wait_done(2 * LAT + 20);
    check("cont_busy_cycles", busy_cycles - bc, 2 * LAT);
    check("cont_valid_pulses", valid_seen - vs, 2);
    check("cont_last_count", int'(result_count), 0);

    run_one(15, 15, 1);

    // Reset during ACC abandons the window; LFSRs restart from their seeds.
    @(posedge clk);
    #1;
    a_in = 4'd8; b_in = 4'd15; mode = 1'b0; cont = 1'b0; start = 1'b1;
    n0 = edge_cnt + 1;
    push_exp(n0, 8, 15, 0);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2 + 60) @(posedge clk);
    #3 rst = 1'b1;
    q.delete();
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_valid", int'(result_valid), 0);
    check("midrst_count", int'(result_count), 0);
    check("midrst_scaled", int'(result_scaled), 0);
    vs = valid_seen;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    run_one(3, 15, 1);
    run_one(8, 8, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stoch_mul_core.md
# stoch_mul_core

Parametrised stochastic-computing multiplier core: two LFSR-driven stochastic number generators convert two WIDTH-bit binary probabilities into bitstreams, which are combined by AND (unipolar) or XNOR (bipolar). Over a window of 2^WIN_LOG2 cycles, the ones in the product stream are counted back to binary. It replaces the fixed 4-bit, free-running, bipolar-only multiplier. Compared with that block, it adds:
- a start/valid handshake,
- a selectable coding mode,
- one-shot or continuous operation,
- a full-range count output with no overflow flag.

The Tiny Tapeout top wrapper instantiates it and maps its ports to `ui_in`/`uio_in`/`uo_out`.

## Interface
Parameters:
- WIDTH, 4: probability operand width; SNG compares `lfsr[WIDTH-1:0] < operand`.
- WIN_LOG2, 7: accumulation window is 2^WIN_LOG2 product bits; WIN_LOG2 ≥ WIDTH, WIN_LOG2 ≤ 16.
- SEED_A, 31'd1: reset value of LFSR A; non-zero.
- SEED_B, 31'h2AAA_5555: reset value of LFSR B; non-zero, ≠ SEED_A.

Ports:
- clk, in, 1: the single clock, rising edge.
- rst_n, in, 1: asynchronous, active-high reset (despite the name, high = reset); all state returns to reset values immediately.
- a_in, in, WIDTH: operand A probability, a_in/2^WIDTH.
- b_in, in, WIDTH: operand B probability.
- mode, in, 1: 0 = unipolar (AND), 1 = bipolar (XNOR).
- cont, in, 1: 1 = restart automatically after each window.
- start, in, 1: request a conversion; sampled only in IDLE.
- busy, out, 1: high in every state except IDLE.
- result_valid, out, 1: one-cycle pulse per completed window.
- result_count, out, WIN_LOG2+1: number of ones in the window, 0..2^WIN_LOG2.
- result_scaled, out, WIDTH: `min(result_count >> (WIN_LOG2-WIDTH), 2^WIDTH-1)`.

## Operation
- LFSRs A and B are 31-bit Fibonacci registers, polynomial x^31+x^28+1:
  - each edge: `lfsr <= {lfsr[29:0], lfsr[27]^lfsr[30]}`;
  - they run continuously whenever not in reset, independent of state.
- States:
  - IDLE, WARM (2 cycles), ACC (2^WIN_LOG2 cycles).
  - WARM uses a 1-bit counter.
  - ACC uses a WIN_LOG2-bit counter `win_cnt`.
- On an edge in IDLE with start=1:
  - latch a_in, b_in, mode into a_q, b_q, mode_q;
  - clear the accumulator;
  - go to WARM.
- Pipeline (all registered):
  - `sn_a <= lfsr_a[WIDTH-1:0] < a_q`;
  - `sn_b <= lfsr_b[WIDTH-1:0] < b_q`;
  - `prod <= mode_q ? ~(sn_a^sn_b) : (sn_a&sn_b)`.
- WARM lasts exactly 2 edges to fill the sn/prod stages, then goes to ACC.
- ACC, each edge: `acc <= acc + prod`. The accumulator is WIN_LOG2+1 bits wide, so no wrap is possible.
- Final ACC edge (`win_cnt == 2^WIN_LOG2-1`):
  - `result_count <= acc + prod`;
  - `result_scaled` is updated from the same value;
  - `result_valid <= 1`.
- Transition after the final ACC edge:
  - cont=0: go to IDLE.
  - cont=1: relatch a_in/b_in/mode, clear acc, go to WARM. busy stays high.
- Holding and ignoring inputs:
  - result_count and result_scaled hold until the next window completes.
  - start is ignored outside IDLE.
  - Operand changes after the latch do not affect the running window.
- Interpretation:
  - Unipolar: count/2^WIN_LOG2 ≈ (a/2^WIDTH)·(b/2^WIDTH).
  - Bipolar: 2·count/2^WIN_LOG2 − 1 ≈ product of the bipolar values. Decoding is left to the consumer.

## Timing
- Reset values:
  - state IDLE; busy 0; result_valid 0;
  - result_count 0; result_scaled 0;
  - acc 0; sn_a, sn_b, prod 0;
  - a_q, b_q, mode_q 0;
  - lfsr_a = SEED_A, lfsr_b = SEED_B.
- Latency: start sampled at edge E0 → result_valid high during the cycle after edge E(2+2^WIN_LOG2). Default: 130 edges.
- busy:
  - rises in the cycle after E0;
  - in one-shot mode, falls in the same cycle that result_valid is high.
- Continuous mode: windows repeat every 2+2^WIN_LOG2 cycles, with result_valid pulsing once per window.
- Reset asserted mid-WARM or mid-ACC: the window is abandoned, no result_valid is produced, and outputs return to their reset values asynchronously.
- Boundary conditions:
  - start and cont both high in IDLE: one-shot behaviour is decided by cont as sampled at the final ACC edge.
  - Operand 0 → SNG stream is constantly 0.
  - Operand 2^WIDTH−1 → SNG stream is 0 only when the low lfsr bits are all ones.
  - Count 2^WIN_LOG2 is representable in result_count; result_scaled saturates at 2^WIDTH−1.

## Test plan
- Reset then idle: rst_n=1 for 3 cycles, then 0. All outputs are 0 and busy=0. After 200 cycles with start=0, result_valid has never pulsed.
- Unipolar zero: mode=0, a=0, b=15, start pulse.
  - busy=1 for exactly 130 cycles;
  - result_valid pulses once, 130 edges after start;
  - result_count=0, result_scaled=0.
- Bipolar full-count: mode=1, a=0, b=0. Both streams are 0, so XNOR=1: result_count=128, result_scaled=15 (saturated).
- Golden-model match: mode=0/1 with a,b ∈ {3, 8, 15}. A bit-exact LFSR reference model yields an identical result_count.
- Continuous and ignored inputs:
  - cont=1 with a=0, b=0, mode=1 gives result_valid pulses 130 cycles apart;
  - switching a=0, mode=0 mid-window leaves that window at 128, and the next window gives 0;
  - start pulses while busy have no effect.
- Reset mid-ACC: assert rst_n at cycle 60 of ACC. Outputs zero immediately. After release, a new start produces a full 130-cycle window and the result matches the model for LFSRs restarted from their seeds.
